// File: rtl/snoop_pkg.sv
// snoop_pkg: MSI line encodings, snoop bus command codes and cache-node FSM states
package snoop_pkg;
    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_M = 2'd2;
    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_RD   = 2'd1;
    localparam logic [1:0] CMD_RDX  = 2'd2;
    localparam logic [1:0] CMD_UPGR = 2'd3;
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, BUS_REQ, WAIT_FILL, RESP} fsm_t;
    // encoding 3 is illegal and behaves as I
    function automatic logic line_valid(input logic [1:0] s);
        return s == ST_S || s == ST_M;
    endfunction
endpackage

// File: rtl/snoop_cache_node_line_store.sv
// snoop_line_store: per-line state/tag/data with a CPU port and a snoop port;
// on a same-line collision the CPU write lands last and wins.
module snoop_line_store
    import snoop_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int TAG_W = 5,
    parameter int DATA_W = 8,
    localparam int IDX_W = $clog2(NUM_LINES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  cpu_index,
    output logic [1:0]        cpu_state,
    output logic [TAG_W-1:0]  cpu_tag,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_wstate,
    input  logic [TAG_W-1:0]  cpu_wtag,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [IDX_W-1:0]  snp_index,
    output logic [1:0]        snp_state,
    output logic [TAG_W-1:0]  snp_tag,
    output logic [DATA_W-1:0] snp_data,
    input  logic              snp_we,
    input  logic [1:0]        snp_wstate
);
    logic [1:0]        st [NUM_LINES];
    logic [TAG_W-1:0]  tg [NUM_LINES];
    logic [DATA_W-1:0] dt [NUM_LINES];

    assign cpu_state = st[cpu_index];
    assign cpu_tag   = tg[cpu_index];
    assign cpu_data  = dt[cpu_index];
    assign snp_state = st[snp_index];
    assign snp_tag   = tg[snp_index];
    assign snp_data  = dt[snp_index];

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                st[i] <= ST_I;
                tg[i] <= '0;
                dt[i] <= '0;
            end
        end else begin
            if (snp_we) st[snp_index] <= snp_wstate;
            if (cpu_we) begin
                st[cpu_index] <= cpu_wstate;
                tg[cpu_index] <= cpu_wtag;
                dt[cpu_index] <= cpu_wdata;
            end
        end
endmodule

// File: rtl/snoop_cache_node.sv
// snoop_cache_node: direct-mapped MSI private cache serving CPU requests and
// answering other nodes' snoop bus transactions.
module snoop_cache_node
    import snoop_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int TAG_W = 5,
    parameter int DATA_W = 8,
    parameter int ID_W = 2,
    parameter int PROC_ID = 0,
    localparam int IDX_W = $clog2(NUM_LINES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_op,
    input  logic [IDX_W-1:0]  cpu_index,
    input  logic [TAG_W-1:0]  cpu_tag,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_cmd_valid,
    output logic [1:0]        bus_cmd,
    output logic [IDX_W-1:0]  bus_index,
    output logic [TAG_W-1:0]  bus_tag,
    output logic [ID_W-1:0]   bus_src,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_cmd,
    input  logic [IDX_W-1:0]  snoop_index,
    input  logic [TAG_W-1:0]  snoop_tag,
    input  logic [ID_W-1:0]   snoop_src,
    output logic              snoop_hit,
    output logic              snoop_wb,
    output logic [DATA_W-1:0] snoop_data,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              wb_valid,
    output logic [IDX_W-1:0]  wb_index,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data
);
    fsm_t state, nxt;
    logic op_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, rdata_d;
    logic [1:0] cmd_q, cmd_d, cmd_eff;
    logic [1:0] line_st, s_st, cpu_wstate, snp_wstate;
    logic [TAG_W-1:0] line_tag, s_tag, cpu_wtag;
    logic [DATA_W-1:0] line_data, s_data, cpu_wdata_s;
    logic cpu_we, snp_we, hit, snoop_act;

    snoop_line_store #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_store (
        .clock(clock), .reset(reset),
        .cpu_index(idx_q), .cpu_state(line_st), .cpu_tag(line_tag), .cpu_data(line_data),
        .cpu_we(cpu_we), .cpu_wstate(cpu_wstate), .cpu_wtag(cpu_wtag), .cpu_wdata(cpu_wdata_s),
        .snp_index(snoop_index), .snp_state(s_st), .snp_tag(s_tag), .snp_data(s_data),
        .snp_we(snp_we), .snp_wstate(snp_wstate)
    );

    assign hit = line_valid(line_st) && line_tag == tag_q;
    // an upgrade whose S copy was snooped away must fetch the line again
    assign cmd_eff = (cmd_q == CMD_UPGR && !hit) ? CMD_RDX : cmd_q;

    assign snoop_act = snoop_valid && snoop_cmd != CMD_NONE && snoop_src != ID_W'(PROC_ID)
                       && line_valid(s_st) && s_tag == snoop_tag;
    assign snp_we = snoop_act && (snoop_cmd != CMD_RD || s_st == ST_M);
    assign snp_wstate = snoop_cmd == CMD_RD ? ST_S : ST_I;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            op_q <= 1'b0;
            idx_q <= '0;
            tag_q <= '0;
            wdata_q <= '0;
            cmd_q <= CMD_NONE;
            rdata_q <= '0;
            snoop_hit <= 1'b0;
            snoop_wb <= 1'b0;
            snoop_data <= '0;
        end else begin
            state <= nxt;
            cmd_q <= cmd_d;
            rdata_q <= rdata_d;
            if (state == IDLE && cpu_req_valid) begin
                op_q <= cpu_op;
                idx_q <= cpu_index;
                tag_q <= cpu_tag;
                wdata_q <= cpu_wdata;
            end
            snoop_hit <= snoop_act;
            snoop_wb <= snoop_act && s_st == ST_M;
            snoop_data <= (snoop_act && s_st == ST_M) ? s_data : '0;
        end

    always_comb begin
        nxt = state;
        cmd_d = cmd_q;
        rdata_d = rdata_q;
        cpu_we = 1'b0;
        cpu_wstate = ST_I;
        cpu_wtag = tag_q;
        cpu_wdata_s = wdata_q;
        case (state)
            IDLE: nxt = cpu_req_valid ? LOOKUP : IDLE;
            LOOKUP:
                if (hit && !op_q) begin
                    nxt = RESP;
                    rdata_d = line_data;
                end else if (hit && line_st == ST_M) begin
                    nxt = RESP;
                    cpu_we = 1'b1;
                    cpu_wstate = ST_M;
                end else if (hit) begin
                    nxt = BUS_REQ;
                    cmd_d = CMD_UPGR;
                end else begin
                    nxt = line_st == ST_M ? WB : BUS_REQ;
                    cmd_d = op_q ? CMD_RDX : CMD_RD;
                end
            WB: begin
                nxt = BUS_REQ;
                cpu_we = 1'b1;
                cpu_wstate = ST_I;
                cpu_wtag = line_tag;
                cpu_wdata_s = line_data;
            end
            BUS_REQ:
                if (bus_gnt) begin
                    cmd_d = cmd_eff;
                    nxt = cmd_eff == CMD_RD ? WAIT_FILL : RESP;
                    cpu_we = cmd_eff != CMD_RD;
                    cpu_wstate = ST_M;
                end
            WAIT_FILL:
                if (fill_valid) begin
                    nxt = RESP;
                    cpu_we = 1'b1;
                    cpu_wstate = ST_S;
                    cpu_wdata_s = fill_data;
                    rdata_d = fill_data;
                end
            RESP: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign cpu_req_ready = state == IDLE;
    assign cpu_resp_valid = state == RESP;
    assign cpu_rdata = rdata_q;
    assign bus_req = state == BUS_REQ && !bus_gnt;
    assign bus_cmd_valid = state == BUS_REQ && bus_gnt;
    assign bus_cmd = bus_cmd_valid ? cmd_eff : CMD_NONE;
    assign bus_index = bus_cmd_valid ? idx_q : '0;
    assign bus_tag = bus_cmd_valid ? tag_q : '0;
    assign bus_src = bus_cmd_valid ? ID_W'(PROC_ID) : '0;
    assign wb_valid = state == WB;
    assign wb_index = wb_valid ? idx_q : '0;
    assign wb_tag = wb_valid ? line_tag : '0;
    assign wb_data = wb_valid ? line_data : '0;
endmodule

// File: tb/tb_snoop_cache_node.sv
// tb_snoop_cache_node: directed and randomized checks of the cache node against
// an array-level MSI reference model, with the bench acting as arbiter and memory.
module tb_snoop_cache_node;
    localparam int NL = 4, TW = 5, DW = 8, IW = 2;

    typedef struct {
        bit bus;
        bit wb;
        logic [TW-1:0] wb_tag;
        logic [DW-1:0] wb_data;
        logic [1:0] cmd;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clock = 1'b0, reset = 1'b1;
    logic cpu_req_valid = 0, cpu_req_ready, cpu_op = 0, cpu_resp_valid;
    logic [1:0] cpu_index = 0;
    logic [TW-1:0] cpu_tag = 0;
    logic [DW-1:0] cpu_wdata = 0, cpu_rdata;
    logic bus_req, bus_gnt = 0, bus_cmd_valid;
    logic [1:0] bus_cmd, bus_index;
    logic [TW-1:0] bus_tag;
    logic [IW-1:0] bus_src;
    logic snoop_valid = 0;
    logic [1:0] snoop_cmd = 0, snoop_index = 0;
    logic [TW-1:0] snoop_tag = 0;
    logic [IW-1:0] snoop_src = 0;
    logic snoop_hit, snoop_wb;
    logic [DW-1:0] snoop_data;
    logic fill_valid = 0;
    logic [DW-1:0] fill_data = 0;
    logic wb_valid;
    logic [1:0] wb_index;
    logic [TW-1:0] wb_tag;
    logic [DW-1:0] wb_data;

    snoop_cache_node #(.NUM_LINES(NL), .TAG_W(TW), .DATA_W(DW), .ID_W(IW), .PROC_ID(0)) dut (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_op(cpu_op),
        .cpu_index(cpu_index), .cpu_tag(cpu_tag), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd_valid(bus_cmd_valid), .bus_cmd(bus_cmd),
        .bus_index(bus_index), .bus_tag(bus_tag), .bus_src(bus_src),
        .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_index(snoop_index),
        .snoop_tag(snoop_tag), .snoop_src(snoop_src),
        .snoop_hit(snoop_hit), .snoop_wb(snoop_wb), .snoop_data(snoop_data),
        .fill_valid(fill_valid), .fill_data(fill_data),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_tag(wb_tag), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0;
    // reference model: 0 = invalid, 1 = shared, 2 = modified
    int m_st [NL];
    logic [TW-1:0] m_tag [NL];
    logic [DW-1:0] m_data [NL];

    int o_resp_cyc, o_req_first, o_cmd_cyc, o_fill_cyc;
    logic [1:0] o_cmd, o_bus_idx;
    logic [TW-1:0] o_bus_tag, o_wb_tag;
    logic [DW-1:0] o_rdata, o_wb_data;
    logic [IW-1:0] o_bus_src;
    bit o_wb, o_snp_hit, o_timeout;

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) begin
            m_st[i] = 0;
            m_tag[i] = '0;
            m_data[i] = '0;
        end
    endfunction

    function automatic exp_t model_txn(input bit op, input int idx, input logic [TW-1:0] tag,
                                       input logic [DW-1:0] wd, input logic [DW-1:0] fd, input bit race);
        exp_t e;
        bit present = m_st[idx] != 0 && m_tag[idx] == tag;
        e.bus = !(present && (!op || m_st[idx] == 2));
        e.wb = !present && m_st[idx] == 2;
        e.wb_tag = m_tag[idx];
        e.wb_data = m_data[idx];
        e.cmd = !e.bus ? 2'd0 : present ? (race ? 2'd2 : 2'd3) : (op ? 2'd2 : 2'd1);
        e.rdata = present ? m_data[idx] : fd;
        if (op) begin
            m_st[idx] = 2;
            m_data[idx] = wd;
        end else if (!present) begin
            m_st[idx] = 1;
            m_data[idx] = fd;
        end
        m_tag[idx] = tag;
        return e;
    endfunction

    function automatic void model_snoop(input logic [1:0] cmd, input int idx, input logic [TW-1:0] tag,
                                        input int src, output bit h, output bit w, output logic [DW-1:0] d);
        h = src != 0 && cmd != 0 && m_st[idx] != 0 && m_tag[idx] == tag;
        w = h && m_st[idx] == 2;
        d = w ? m_data[idx] : '0;
        if (h) m_st[idx] = cmd == 2'd1 ? 1 : 0;
    endfunction

    task automatic run_txn(input bit op, input int idx, input logic [TW-1:0] tag, input logic [DW-1:0] wd,
                           input int gwait, input int fwait, input logic [DW-1:0] fd, input bit race);
        int cyc = 0, reqc = 0;
        bit last_req = 0, done = 0, snp_sent = 0;
        o_resp_cyc = -1; o_req_first = -1; o_cmd_cyc = -1; o_fill_cyc = -1;
        o_cmd = 0; o_wb = 0; o_snp_hit = 0; o_rdata = 0;
        @(negedge clock);
        cpu_req_valid = 1; cpu_op = op; cpu_index = 2'(idx); cpu_tag = tag; cpu_wdata = wd;
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            cpu_req_valid = 0;
            bus_gnt = last_req && reqc > gwait;
            fill_valid = o_cmd == 2'd1 && o_cmd_cyc >= 0 && o_fill_cyc < 0 && cyc > o_cmd_cyc + fwait;
            if (fill_valid) o_fill_cyc = cyc;
            fill_data = fd;
            snoop_valid = race && reqc == 2 && !snp_sent;
            if (snoop_valid) begin
                snp_sent = 1;
                snoop_cmd = 2'd2; snoop_index = 2'(idx); snoop_tag = tag; snoop_src = 2'd1;
            end
            #1;
            if (bus_req) begin
                if (o_req_first < 0) o_req_first = cyc;
                reqc++;
                last_req = 1;
            end
            if (bus_cmd_valid) begin
                o_cmd = bus_cmd; o_cmd_cyc = cyc; last_req = 0;
                o_bus_idx = bus_index; o_bus_tag = bus_tag; o_bus_src = bus_src;
            end
            if (wb_valid) begin
                o_wb = 1; o_wb_tag = wb_tag; o_wb_data = wb_data;
            end
            if (snoop_hit) o_snp_hit = 1;
            if (cpu_resp_valid) begin
                o_resp_cyc = cyc; o_rdata = cpu_rdata; done = 1;
            end
        end
        bus_gnt = 0; fill_valid = 0; snoop_valid = 0;
        o_timeout = !done;
    endtask

    task automatic do_snoop(input logic [1:0] cmd, input int idx, input logic [TW-1:0] tag, input int src,
                            output bit h, output bit w, output logic [DW-1:0] d, output bit lingers);
        @(negedge clock);
        snoop_valid = 1; snoop_cmd = cmd; snoop_index = 2'(idx); snoop_tag = tag; snoop_src = 2'(src);
        @(negedge clock);
        snoop_valid = 0;
        #1;
        h = snoop_hit; w = snoop_wb; d = snoop_data;
        @(negedge clock);
        #1;
        lingers = snoop_hit || snoop_wb || snoop_data != 0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1;
        repeat (2) @(negedge clock);
        #1;
        v = {cpu_req_ready, cpu_resp_valid, bus_req, bus_cmd_valid, wb_valid, snoop_hit, snoop_wb,
             |{bus_cmd, bus_index, bus_tag, bus_src, snoop_data, cpu_rdata, wb_index, wb_tag, wb_data}};
        n_cmp++;
        if (v !== 8'b1000_0000) begin n_bad++; $display("FAIL reset_outputs: got %b want 10000000", v); end
        reset = 0;
        model_clear();
    endtask

    task automatic test_read_miss();
        exp_t e = model_txn(0, 1, 5'd12, 8'd0, 8'd55, 0);
        run_txn(0, 1, 5'd12, 8'd0, 1, 1, 8'd55, 0);
        n_cmp++;
        if (o_timeout || o_rdata !== 8'd55) begin n_bad++; $display("FAIL read_miss_data: got %0d want 55", o_rdata); end
        n_cmp++;
        if (o_cmd !== 2'd1 || o_bus_idx !== 2'd1 || o_bus_tag !== 5'd12 || o_bus_src !== 2'd0) begin
            n_bad++; $display("FAIL read_miss_cmd: got cmd %0d idx %0d tag %0d src %0d want 1/1/12/0", o_cmd, o_bus_idx, o_bus_tag, o_bus_src);
        end
        n_cmp++;
        if (o_resp_cyc !== o_fill_cyc + 1 || o_req_first !== 2) begin
            n_bad++; $display("FAIL read_miss_timing: got req %0d resp %0d want req 2 resp %0d", o_req_first, o_resp_cyc, o_fill_cyc + 1);
        end
        if (e.cmd != 2'd1) $display("note: model disagrees with read-miss scenario setup");
    endtask

    task automatic test_read_hit();
        exp_t e = model_txn(0, 1, 5'd12, 8'd0, 8'd0, 0);
        run_txn(0, 1, 5'd12, 8'd0, 0, 0, 8'd0, 0);
        n_cmp++;
        if (o_resp_cyc !== 2 || o_req_first !== -1) begin
            n_bad++; $display("FAIL read_hit_latency: got resp %0d req %0d want resp 2 req -1", o_resp_cyc, o_req_first);
        end
        n_cmp++;
        if (o_rdata !== e.rdata) begin n_bad++; $display("FAIL read_hit_data: got %0d want %0d", o_rdata, e.rdata); end
    endtask

    task automatic test_write_upgrade();
        exp_t e = model_txn(1, 1, 5'd12, 8'h33, 8'd0, 0);
        run_txn(1, 1, 5'd12, 8'h33, 2, 0, 8'd0, 0);
        n_cmp++;
        if (o_cmd !== 2'd3 || o_resp_cyc !== o_cmd_cyc + 1) begin
            n_bad++; $display("FAIL upgrade_cmd: got cmd %0d resp %0d want cmd 3 resp %0d", o_cmd, o_resp_cyc, o_cmd_cyc + 1);
        end
        e = model_txn(0, 1, 5'd12, 8'd0, 8'd0, 0);
        run_txn(0, 1, 5'd12, 8'd0, 0, 0, 8'd0, 0);
        n_cmp++;
        if (o_rdata !== 8'h33 || o_resp_cyc !== 2) begin
            n_bad++; $display("FAIL upgrade_data: got %0h at %0d want 33 at 2", o_rdata, o_resp_cyc);
        end
    endtask

    task automatic test_snoop_supply();
        bit h, w, lin, eh, ew;
        logic [DW-1:0] d, ed;
        exp_t e = model_txn(1, 1, 5'd12, 8'd90, 8'd0, 0);
        run_txn(1, 1, 5'd12, 8'd90, 0, 0, 8'd0, 0);
        n_cmp++;
        if (o_resp_cyc !== 2 || o_req_first !== -1) begin
            n_bad++; $display("FAIL write_hit_m: got resp %0d req %0d want 2/-1", o_resp_cyc, o_req_first);
        end
        model_snoop(2'd1, 1, 5'd12, 1, eh, ew, ed);
        do_snoop(2'd1, 1, 5'd12, 1, h, w, d, lin);
        n_cmp++;
        if ({h, w, d, lin} !== {1'b1, 1'b1, 8'd90, 1'b0}) begin
            n_bad++; $display("FAIL snoop_m_busrd: got hit %0b wb %0b data %0d linger %0b want 1 1 90 0", h, w, d, lin);
        end
        model_snoop(2'd1, 1, 5'd12, 3, eh, ew, ed);
        do_snoop(2'd1, 1, 5'd12, 3, h, w, d, lin);
        n_cmp++;
        if ({h, w} !== 2'b10) begin n_bad++; $display("FAIL snoop_s_busrd: got hit %0b wb %0b want 1 0", h, w); end
        model_snoop(2'd2, 1, 5'd12, 0, eh, ew, ed);
        do_snoop(2'd2, 1, 5'd12, 0, h, w, d, lin);
        n_cmp++;
        if (h !== 1'b0) begin n_bad++; $display("FAIL snoop_own_src: got hit %0b want 0", h); end
        if (e.bus) $display("note: write-hit-M scenario setup was not a hit in M");
    endtask

    task automatic test_writeback();
        exp_t e = model_txn(1, 2, 5'd14, 8'd50, 8'd0, 0);
        run_txn(1, 2, 5'd14, 8'd50, 0, 0, 8'd0, 0);
        e = model_txn(1, 2, 5'd3, 8'h77, 8'd0, 0);
        run_txn(1, 2, 5'd3, 8'h77, 1, 0, 8'd0, 0);
        n_cmp++;
        if (!o_wb || o_wb_tag !== 5'd14 || o_wb_data !== 8'd50) begin
            n_bad++; $display("FAIL writeback: got wb %0b tag %0d data %0d want 1 14 50", o_wb, o_wb_tag, o_wb_data);
        end
        n_cmp++;
        if (o_cmd !== 2'd2 || o_req_first !== 3) begin
            n_bad++; $display("FAIL writeback_cmd: got cmd %0d req %0d want 2 3", o_cmd, o_req_first);
        end
        e = model_txn(0, 2, 5'd3, 8'd0, 8'd0, 0);
        run_txn(0, 2, 5'd3, 8'd0, 0, 0, 8'd0, 0);
        n_cmp++;
        if (o_rdata !== 8'h77 || o_req_first !== -1) begin
            n_bad++; $display("FAIL writeback_newline: got %0h req %0d want 77 -1", o_rdata, o_req_first);
        end
    endtask

    task automatic test_upgrade_race();
        exp_t e;
        run_txn(0, 3, 5'd9, 8'd0, 0, 0, 8'h21, 0);
        e = model_txn(0, 3, 5'd9, 8'd0, 8'h21, 0);
        e = model_txn(1, 3, 5'd9, 8'h5a, 8'd0, 1);
        run_txn(1, 3, 5'd9, 8'h5a, 5, 0, 8'd0, 1);
        n_cmp++;
        if (!o_snp_hit || o_cmd !== 2'd2) begin
            n_bad++; $display("FAIL upgrade_race: got snoop_hit %0b cmd %0d want 1 2", o_snp_hit, o_cmd);
        end
        e = model_txn(0, 3, 5'd9, 8'd0, 8'd0, 0);
        run_txn(0, 3, 5'd9, 8'd0, 0, 0, 8'd0, 0);
        n_cmp++;
        if (o_rdata !== 8'h5a || o_resp_cyc !== 2) begin
            n_bad++; $display("FAIL upgrade_race_line: got %0h at %0d want 5a at 2", o_rdata, o_resp_cyc);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clock);
        cpu_req_valid = 1; cpu_op = 0; cpu_index = 2'd0; cpu_tag = 5'd9;
        @(negedge clock);
        cpu_req_valid = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        #1;
        n_cmp++;
        if ({cpu_req_ready, bus_req, bus_cmd_valid, cpu_resp_valid, wb_valid} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_abort: got %b want 10000", {cpu_req_ready, bus_req, bus_cmd_valid, cpu_resp_valid, wb_valid});
        end
        @(negedge clock);
        reset = 0;
        model_clear();
        run_txn(0, 1, 5'd12, 8'd0, 0, 0, 8'h44, 0);
        n_cmp++;
        if (o_req_first !== 2 || o_rdata !== 8'h44) begin
            n_bad++; $display("FAIL reset_clears_array: got req %0d data %0h want 2 44", o_req_first, o_rdata);
        end
        void'(model_txn(0, 1, 5'd12, 8'd0, 8'h44, 0));
    endtask

    task automatic test_random();
        for (int k = 0; k < 80; k++) begin
            bit op = 1'($urandom_range(0, 1));
            int idx = $urandom_range(0, NL - 1);
            logic [TW-1:0] tag = 5'(12 + $urandom_range(0, 2));
            logic [DW-1:0] wd = 8'($urandom), fd = 8'($urandom);
            int gw = $urandom_range(0, 3), fw = $urandom_range(0, 2);
            bit race = op && m_st[idx] == 1 && m_tag[idx] == tag && $urandom_range(0, 1) == 1;
            exp_t e;
            if (race) gw = 4;
            e = model_txn(op, idx, tag, wd, fd, race);
            run_txn(op, idx, tag, wd, gw, fw, fd, race);
            n_cmp++;
            if (o_timeout || (o_req_first >= 0) !== e.bus) begin
                n_bad++; $display("FAIL rand_bus_use[%0d]: got req %0d timeout %0b want bus %0b", k, o_req_first, o_timeout, e.bus);
            end
            n_cmp++;
            if (e.bus ? (o_cmd !== e.cmd || o_bus_idx !== 2'(idx) || o_bus_tag !== tag || o_req_first !== 2 + int'(e.wb))
                      : o_resp_cyc !== 2) begin
                n_bad++; $display("FAIL rand_cmd[%0d]: got cmd %0d idx %0d tag %0d req %0d resp %0d want cmd %0d idx %0d tag %0d wb %0b",
                                  k, o_cmd, o_bus_idx, o_bus_tag, o_req_first, o_resp_cyc, e.cmd, idx, tag, e.wb);
            end
            n_cmp++;
            if (o_wb !== e.wb || (e.wb && (o_wb_tag !== e.wb_tag || o_wb_data !== e.wb_data))) begin
                n_bad++; $display("FAIL rand_wb[%0d]: got %0b %0d %0h want %0b %0d %0h", k, o_wb, o_wb_tag, o_wb_data, e.wb, e.wb_tag, e.wb_data);
            end
            if (e.bus) begin
                n_cmp++;
                if (o_resp_cyc !== (e.cmd == 2'd1 ? o_fill_cyc : o_cmd_cyc) + 1) begin
                    n_bad++; $display("FAIL rand_resp_timing[%0d]: got %0d cmd %0d fill %0d", k, o_resp_cyc, o_cmd_cyc, o_fill_cyc);
                end
            end
            if (!op) begin
                n_cmp++;
                if (o_rdata !== e.rdata) begin n_bad++; $display("FAIL rand_rdata[%0d]: got %0h want %0h", k, o_rdata, e.rdata); end
            end
            if ($urandom_range(0, 2) == 0) begin
                logic [1:0] sc = 2'($urandom_range(1, 3));
                int si = $urandom_range(0, NL - 1), ss = $urandom_range(0, 3);
                logic [TW-1:0] st = 5'(12 + $urandom_range(0, 2));
                bit h, w, lin, eh, ew;
                logic [DW-1:0] d, ed;
                model_snoop(sc, si, st, ss, eh, ew, ed);
                do_snoop(sc, si, st, ss, h, w, d, lin);
                n_cmp++;
                if ({h, w, d, lin} !== {eh, ew, ed, 1'b0}) begin
                    n_bad++; $display("FAIL rand_snoop[%0d]: got %0b %0b %0h linger %0b want %0b %0b %0h", k, h, w, d, lin, eh, ew, ed);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_upgrade();
        test_snoop_supply();
        test_writeback();
        test_upgrade_race();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/snoop_cache_node.md
# snoop_cache_node

Parametrised snooping-cache node: one direct-mapped, MSI-coherent private cache per processor. It serves CPU read/write requests and arbitrates for the shared snoop bus. It answers other nodes' bus transactions with hit, writeback and data-supply responses. N instances plus a bus arbiter and memory model form the multiprocessor system; this block replaces the fixed 4-line, 2-machine processor node.

## Interface
Parameters:
- NUM_LINES, 4: cache lines (power of 2, ≥2); IDX_W = log2(NUM_LINES)
- TAG_W, 5: tag width
- DATA_W, 8: line = one word of DATA_W bits
- ID_W, 2: processor-id width
- PROC_ID, 0: this node's id

Ports:
- clock  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- cpu_req_valid / cpu_req_ready  in / out  1  CPU request handshake
- cpu_op  in  1  0 = read, 1 = write
- cpu_index, cpu_tag, cpu_wdata  in  IDX_W / TAG_W / DATA_W  request address and data
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read result, valid with cpu_resp_valid
- bus_req / bus_gnt  out / in  1  bus arbitration
- bus_cmd_valid  out  1  one-cycle pulse on the grant cycle
- bus_cmd  out  2  00 none, 01 BusRd, 10 BusRdX, 11 BusUpgr
- bus_index, bus_tag, bus_src  out  IDX_W / TAG_W / ID_W  command address; bus_src = PROC_ID
- snoop_valid, snoop_cmd, snoop_index, snoop_tag, snoop_src  in  1 / 2 / IDX_W / TAG_W / ID_W  broadcast bus command
- snoop_hit, snoop_wb  out  1  registered snoop response
- snoop_data  out  DATA_W  supplied data when snoop_wb = 1
- fill_valid, fill_data  in  1 / DATA_W  BusRd fill (from memory or owner)
- wb_valid, wb_index, wb_tag, wb_data  out  1 / IDX_W / TAG_W / DATA_W  victim writeback to memory, one-cycle pulse

## Operation
- Line state: I = 0, S = 1, M = 2; 3 is illegal and treated as I.
- Per line: state, tag, data. Reset sets all lines to I and tag/data to 0.
- FSM: IDLE → LOOKUP → (RESP | WB | BUS_REQ) → WAIT_FILL → RESP → IDLE.
- cpu_req_ready = 1 only in IDLE. Accept registers op/index/tag/wdata.
- LOOKUP: hit = tag match and state ≠ I.
  - Read hit → RESP.
  - Write hit in M → write data → RESP.
  - Write hit in S → BUS_REQ, cmd BusUpgr.
  - Miss with victim in M → WB; wb_valid pulses with victim tag/data, line becomes I, then BUS_REQ.
  - Miss otherwise → BUS_REQ: read uses BusRd, write uses BusRdX.
- BUS_REQ: bus_req is held until bus_gnt. On the grant cycle bus_cmd_valid = 1 and bus_req drops.
  - BusRd → WAIT_FILL. On fill_valid: line = {S, tag, fill_data}; cpu_rdata = fill_data.
  - BusRdX/BusUpgr → line = {M, tag, wdata} on the grant cycle → RESP.
- RESP: cpu_resp_valid pulses one cycle → IDLE.
- Snoop path runs independently of the FSM. It acts when snoop_valid and snoop_src ≠ PROC_ID and the addressed line matches snoop_tag with state ≠ I.
  - BusRd: S → snoop_hit = 1. M → snoop_hit = 1, snoop_wb = 1, snoop_data = line data, state S.
  - BusRdX/BusUpgr: S → I with snoop_hit = 1. M → I with snoop_hit = 1, snoop_wb = 1, data supplied.
  - Own commands (snoop_src = PROC_ID) are ignored.
- Upgrade race: if a snoop invalidates the pending line while in BUS_REQ with BusUpgr, the command becomes BusRdX before the grant.
- Same-cycle snoop and CPU update to one line: the snoop state change is applied first, and the CPU update overwrites it.

## Timing
- Read hit: accept at cycle 0, LOOKUP 1, cpu_resp_valid at 2.
- Write hit in M: same latency; data is visible to a read accepted at cycle 3.
- Miss latency: 2 + (1 if writeback) + grant wait + fill wait + 1.
- fill_valid is legal from one cycle after the bus_cmd_valid cycle. fill_valid outside WAIT_FILL is ignored.
- Snoop responses are registered one cycle after snoop_valid and held one cycle, then return to 0.
- Reset values: all outputs 0 except cpu_req_ready = 1. Reset mid-transaction aborts it, clears the array, and asserts no pulse.

## Structure
- Package snoop_pkg holds the MSI encodings, bus_cmd codes and the FSM state enum; it is shared with the arbiter and memory model.
- Sub-module snoop_line_store holds the state/tag/data arrays. It has one CPU read/write port and one snoop read/write port, and enforces the snoop-then-CPU write order.

## Test plan
- After reset, read idx 1 tag 12 → miss. BusRd issued; fill_data 55 → cpu_rdata 55, line S.
- Repeat that read → hit, cpu_resp_valid at cycle 2, no bus_req.
- Write 0x33 to a line in S → BusUpgr on grant → line M with data 0x33, resp 1 cycle later.
- Node in M (data 90) snoops BusRd from id 1 → next cycle snoop_hit = 1, snoop_wb = 1, snoop_data = 90, line S.
- Write miss to idx 2 whose victim is M (tag 14, data 50) → wb_valid with tag 14, data 50, then BusRdX, line {M, new tag, wdata}.
- Pending BusUpgr with gnt held low; inject a BusRdX snoop to the same line → line I, and the granted command is BusRdX.
